// File: rtl/temp_conv_scheduler.sv
// temp_conv_scheduler
//   Time-shares a single ADC-to-temperature converter among NCH thermistor channels.
//   A free-running period timer starts a scan; each scan converts every enabled channel
//   in ascending order, one at a time, and keeps per-channel results, valid flags and faults.
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   ch_enable_i    per-channel enable, sampled when the scan reaches that channel
//   adc_in_i       raw 12-bit ADC codes, channel k at [12k+11:12k]
//   conv_start_o   1-cycle start strobe to the converter
//   conv_adc_o     ADC code of the current conversion (held until done/timeout)
//   conv_sel_o     index of the channel being converted
//   conv_done_i    converter result strobe
//   conv_temp_i    signed converter result in deg C
//   temp_out_o     last good signed temperature per channel
//   temp_valid_o   channel has at least one good result
//   fault_o        per channel: 00 ok, 01 timeout, 10 short, 11 open
//   busy_o         scan in progress
//   scan_done_o    1-cycle pulse at the end of a scan
//   overrun_o      1-cycle pulse when a period tick arrives while busy
module temp_conv_scheduler #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned PERIOD  = 50000,
  parameter int unsigned TIMEOUT = 128,
  parameter int unsigned CW      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    ch_enable_i,
  input  logic [NCH*12-1:0] adc_in_i,
  output logic              conv_start_o,
  output logic [11:0]       conv_adc_o,
  output logic [CW-1:0]     conv_sel_o,
  input  logic              conv_done_i,
  input  logic [11:0]       conv_temp_i,
  output logic [NCH*12-1:0] temp_out_o,
  output logic [NCH-1:0]    temp_valid_o,
  output logic [NCH*2-1:0]  fault_o,
  output logic              busy_o,
  output logic              scan_done_o,
  output logic              overrun_o
);

  localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  localparam logic signed [11:0] TempShort = 12'sd300;
  localparam logic signed [11:0] TempOpen  = -12'sd55;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StStart,
    StWait,
    StStore,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       cnt_q, cnt_d;
  // One extra bit so the channel index can reach NCH (end-of-scan marker).
  logic [CW:0]         ch_q, ch_d;
  logic [TW-1:0]       to_q, to_d;
  logic [11:0]         adc_q, adc_d;
  logic [CW-1:0]       sel_q, sel_d;
  logic [11:0]         cap_q, cap_d;
  logic [NCH*12-1:0]   temp_q, temp_d;
  logic [NCH-1:0]      valid_q, valid_d;
  logic [NCH*2-1:0]    fault_q, fault_d;

  logic        tick;
  logic        ch_last;
  logic        timed_out;
  logic        en_cur;
  logic [11:0] adc_cur;

  assign tick      = (cnt_q == PW'(PERIOD - 1));
  assign ch_last   = (ch_q == (CW + 1)'(NCH));
  assign timed_out = (to_q == TW'(TIMEOUT - 1));
  assign cnt_d     = tick ? '0 : cnt_q + 1'b1;

  // Per-channel mux of enable and ADC code; out-of-range index yields zero.
  always_comb begin
    en_cur  = 1'b0;
    adc_cur = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (ch_q == (CW + 1)'(k)) begin
        en_cur  = ch_enable_i[k];
        adc_cur = adc_in_i[12*k +: 12];
      end
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ch_q    <= '0;
      to_q    <= '0;
      adc_q   <= '0;
      sel_q   <= '0;
      cap_q   <= '0;
      temp_q  <= '0;
      valid_q <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      to_q    <= to_d;
      adc_q   <= adc_d;
      sel_q   <= sel_d;
      cap_q   <= cap_d;
      temp_q  <= temp_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (tick) state_d = StSelect;
      StSelect: begin
        if (ch_last)     state_d = StDone;
        else if (en_cur) state_d = StStart;
      end
      StStart:  state_d = StWait;
      StWait: begin
        // A result arriving on the last timeout cycle still counts.
        if (conv_done_i)    state_d = StStore;
        else if (timed_out) state_d = StSelect;
      end
      StStore:  state_d = StSelect;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    ch_d    = ch_q;
    to_d    = to_q;
    adc_d   = adc_q;
    sel_d   = sel_q;
    cap_d   = cap_q;
    temp_d  = temp_q;
    valid_d = valid_q;
    fault_d = fault_q;
    case (state_q)
      StIdle: if (tick) ch_d = '0;
      StSelect: begin
        if (!ch_last) begin
          if (en_cur) begin
            adc_d = adc_cur;
            sel_d = ch_q[CW-1:0];
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      StStart: to_d = '0;
      StWait: begin
        if (conv_done_i) begin
          cap_d = conv_temp_i;
        end else if (timed_out) begin
          for (int k = 0; k < int'(NCH); k++) begin
            if (ch_q == (CW + 1)'(k)) fault_d[2*k +: 2] = 2'b01;
          end
          ch_d = ch_q + 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      StStore: begin
        for (int k = 0; k < int'(NCH); k++) begin
          if (ch_q == (CW + 1)'(k)) begin
            if ($signed(cap_q) == TempShort) begin
              fault_d[2*k +: 2] = 2'b10;
            end else if ($signed(cap_q) == TempOpen) begin
              fault_d[2*k +: 2] = 2'b11;
            end else begin
              temp_d[12*k +: 12] = cap_q;
              fault_d[2*k +: 2]  = 2'b00;
              valid_d[k]         = 1'b1;
            end
          end
        end
        ch_d = ch_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    conv_start_o = (state_q == StStart);
    busy_o       = (state_q != StIdle);
    scan_done_o  = (state_q == StDone);
    // Ticks while busy are dropped, not queued.
    overrun_o    = tick && (state_q != StIdle);
    conv_adc_o   = adc_q;
    conv_sel_o   = sel_q;
    temp_out_o   = temp_q;
    temp_valid_o = valid_q;
    fault_o      = fault_q;
  end

endmodule
